bargraph_frame_renderer: RTL

- Upstream stage of the RGB LED bargraph driver. It turns 16 bar heights and colours, plus per-bar peak-hold markers, into a full 16x16 8-bit pixel frame.
- It writes the frame into the driver's back display buffer through the driver's write port. It then requests a buffer flip and waits for the driver to report that the flip has happened.
- One frame costs 256 write cycles plus the flip wait.

---
 rtl/bargraph_frame_renderer.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/bargraph_frame_renderer.sv
// ---------------------------------------------------------------------------
// bargraph_frame_renderer
//
// Purpose:
//   Upstream stage of the RGB LED bargraph driver. Holds 16 staged bar
//   heights/colours, and on request renders a complete 16x16 8-bit pixel
//   frame into the driver's back display buffer. The frame also carries a
//   per-bar peak-hold marker. When the frame is written, the block requests
//   a buffer flip and waits for the driver to confirm it.
//
// Ports:
//   clk            system clock (the driver's wr_clk is tied to it)
//   rst            synchronous, active-high reset
//   bar_wr         strobe: stage bar_height/bar_color into entry bar_idx
//   bar_idx        bar (column) index 0..15
//   bar_height     bar height in pixels; values above 16 clamp to 16
//   bar_color      bar pixel value
//   frame_go       single-cycle render request, honoured only when idle
//   busy           high while a frame is in progress
//   frame_done     one-cycle pulse once the flip has been confirmed
//   wr             display-memory write enable
//   wr_addr        {buffer, row[3:0], col[3:0]}
//   wr_data        pixel value
//   buffer_select  display buffer requested from the driver
//   buffer_current buffer the driver is currently displaying
// ---------------------------------------------------------------------------
module bargraph_frame_renderer #(
    parameter logic [7:0] BG_COLOR   = 8'h00,
    parameter logic [7:0] PEAK_COLOR = 8'hFF,
    parameter int         PEAK_HOLD  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bar_wr,
    input  logic [3:0] bar_idx,
    input  logic [4:0] bar_height,
    input  logic [7:0] bar_color,
    input  logic       frame_go,
    output logic       busy,
    output logic       frame_done,
    output logic       wr,
    output logic [8:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       buffer_select,
    input  logic       buffer_current
);

    // Hold counter must be able to hold the value PEAK_HOLD itself.
    localparam int                HOLD_W    = (PEAK_HOLD < 2) ? 1 : $clog2(PEAK_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(PEAK_HOLD);
    localparam logic [4:0]        MAX_H     = 5'd16;

    typedef enum logic [1:0] {
        IDLE,
        RENDER,
        SWAP,
        WAIT_FLIP
    } state_t;

    state_t state_q, state_d;

    logic       busy_q, busy_d;
    logic       frame_done_q, frame_done_d;
    logic       wr_q, wr_d;
    logic [8:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       buffer_select_q, buffer_select_d;
    logic       back_q, back_d;

    // Staging set: written by bar_wr at any time, only sampled at frame start.
    logic [4:0] stg_height_q [16];
    logic [4:0] stg_height_d [16];
    logic [7:0] stg_color_q  [16];
    logic [7:0] stg_color_d  [16];

    // Active set: frozen for the whole frame in progress.
    logic [4:0] act_height_q [16];
    logic [4:0] act_height_d [16];
    logic [7:0] act_color_q  [16];
    logic [7:0] act_color_d  [16];

    // Peak-hold tracking, updated once per rendered frame.
    logic [4:0]        peak_q [16];
    logic [4:0]        peak_d [16];
    logic [HOLD_W-1:0] hold_q [16];
    logic [HOLD_W-1:0] hold_d [16];

    // The write address doubles as the scan cursor; this is the next pixel.
    logic [7:0] next_pix;
    assign next_pix = wr_addr_q[7:0] + 8'd1;

    // Pixel colour for one row of one column. Row 0 is the bottom of the bar;
    // the bar wins over the peak marker, so a peak inside the bar is hidden.
    function automatic logic [7:0] pixel_of(input logic [3:0] pix_row,
                                            input logic [4:0] col_height,
                                            input logic [4:0] col_peak,
                                            input logic [7:0] col_color);
        logic [4:0] row_ext;
        row_ext = {1'b0, pix_row};
        if (row_ext < col_height) begin
            return col_color;
        end else if ((col_peak != 5'd0) && (row_ext == (col_peak - 5'd1))) begin
            return PEAK_COLOR;
        end else begin
            return BG_COLOR;
        end
    endfunction

    // Next-state and output logic. Everything is registered, so the first
    // pixel of a frame has to be computed from the freshly loaded active set
    // (the _d values) in the same cycle frame_go is accepted.
    always_comb begin
        state_d         = state_q;
        busy_d          = busy_q;
        frame_done_d    = 1'b0;
        wr_d            = 1'b0;
        wr_addr_d       = wr_addr_q;
        wr_data_d       = wr_data_q;
        buffer_select_d = buffer_select_q;
        back_d          = back_q;
        stg_height_d    = stg_height_q;
        stg_color_d     = stg_color_q;
        act_height_d    = act_height_q;
        act_color_d     = act_color_q;
        peak_d          = peak_q;
        hold_d          = hold_q;

        // Staging writes are accepted in every state. A write in the same
        // cycle as an accepted frame_go lands after the copy below reads the
        // old staging value, so it only reaches the following frame.
        if (bar_wr) begin
            stg_height_d[bar_idx] = (bar_height > MAX_H) ? MAX_H : bar_height;
            stg_color_d[bar_idx]  = bar_color;
        end

        case (state_q)
            IDLE: begin
                // frame_go arriving together with frame_done is dropped.
                if (frame_go && !frame_done_q) begin
                    for (int i = 0; i < 16; i++) begin
                        act_height_d[i] = stg_height_q[i];
                        act_color_d[i]  = stg_color_q[i];
                        if (stg_height_q[i] >= peak_q[i]) begin
                            peak_d[i] = stg_height_q[i];
                            hold_d[i] = HOLD_INIT;
                        end else if (hold_q[i] != '0) begin
                            hold_d[i] = hold_q[i] - HOLD_W'(1);
                        end else begin
                            // Height is strictly below the peak here, so one
                            // step of decay can never drop under the height.
                            peak_d[i] = peak_q[i] - 5'd1;
                        end
                    end
                    back_d    = ~buffer_select_q;
                    busy_d    = 1'b1;
                    wr_d      = 1'b1;
                    wr_addr_d = {back_d, 8'd0};
                    wr_data_d = pixel_of(4'd0, act_height_d[0], peak_d[0], act_color_d[0]);
                    state_d   = RENDER;
                end
            end

            RENDER: begin
                if (wr_addr_q[7:0] == 8'hFF) begin
                    state_d = SWAP;
                end else begin
                    wr_d      = 1'b1;
                    wr_addr_d = {back_q, next_pix};
                    wr_data_d = pixel_of(next_pix[7:4],
                                         act_height_q[next_pix[3:0]],
                                         peak_q[next_pix[3:0]],
                                         act_color_q[next_pix[3:0]]);
                end
            end

            SWAP: begin
                buffer_select_d = back_q;
                state_d         = WAIT_FLIP;
            end

            WAIT_FLIP: begin
                // No timeout: the driver flips only at its own frame boundary.
                if (buffer_current == buffer_select_q) begin
                    frame_done_d = 1'b1;
                    busy_d       = 1'b0;
                    state_d      = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and data registers; reset aborts any frame in flight and clears
    // staging, active and peak-hold state alike.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            busy_q          <= 1'b0;
            frame_done_q    <= 1'b0;
            wr_q            <= 1'b0;
            wr_addr_q       <= '0;
            wr_data_q       <= '0;
            buffer_select_q <= 1'b0;
            back_q          <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                stg_height_q[i] <= '0;
                stg_color_q[i]  <= '0;
                act_height_q[i] <= '0;
                act_color_q[i]  <= '0;
                peak_q[i]       <= '0;
                hold_q[i]       <= '0;
            end
        end else begin
            state_q         <= state_d;
            busy_q          <= busy_d;
            frame_done_q    <= frame_done_d;
            wr_q            <= wr_d;
            wr_addr_q       <= wr_addr_d;
            wr_data_q       <= wr_data_d;
            buffer_select_q <= buffer_select_d;
            back_q          <= back_d;
            for (int i = 0; i < 16; i++) begin
                stg_height_q[i] <= stg_height_d[i];
                stg_color_q[i]  <= stg_color_d[i];
                act_height_q[i] <= act_height_d[i];
                act_color_q[i]  <= act_color_d[i];
                peak_q[i]       <= peak_d[i];
                hold_q[i]       <= hold_d[i];
            end
        end
    end

    assign busy          = busy_q;
    assign frame_done    = frame_done_q;
    assign wr            = wr_q;
    assign wr_addr       = wr_addr_q;
    assign wr_data       = wr_data_q;
    assign buffer_select = buffer_select_q;

endmodule
